trb_mem_arbiter: RTL and testbench
==================================

Name: trb_mem_arbiter

Overview:
Arbitrates the single-port trace buffer memory between two requesters: the trace side (TraceLogger) and the host side (readout logger).
Issues the per-side RW turn and write/read allow signals, sequences one write phase and one read phase per slot, and returns read data.
Maintains the buffer fill level, so the trace side cannot overrun unread data and the host cannot read an empty buffer.

Parameters:
TRB_WIDTH, 32, memory word width in bits
TRB_DEPTH, 16, memory depth in words (power of two, >=4)
PTR_W, $clog2(TRB_DEPTH), pointer width

Ports:
CLK_I  in  1  clock
RST_NI  in  1  asynchronous active-low reset
ENABLE_I  in  1  arbiter enable
CLEAR_I  in  1  synchronous fill clear
TRG_DELAYED_I  in  1  delayed trigger fired; freezes trace writes
T_REQ_I / H_REQ_I  in  1  side requests a slot
T_WRITE_I / H_WRITE_I  in  1  side wants a write in its slot
T_WRITE_PTR_I / H_WRITE_PTR_I  in  PTR_W  write address
T_READ_PTR_I / H_READ_PTR_I  in  PTR_W  read address
T_DATA_I / H_DATA_I  in  TRB_WIDTH  write data
T_TURN_O / H_TURN_O  out  1  side owns the current slot
T_WRITE_ALLOW_O / H_WRITE_ALLOW_O  out  1  write permitted
T_READ_ALLOW_O / H_READ_ALLOW_O  out  1  read permitted
T_DATA_O / H_DATA_O  out  TRB_WIDTH  registered read data
T_VALID_O / H_VALID_O  out  1  one-cycle pulse: DATA_O updated
MEM_EN_O, MEM_WE_O  out  1  memory enable, write enable
MEM_ADDR_O  out  PTR_W  memory address
MEM_WDATA_O  out  TRB_WIDTH  memory write data
MEM_RDATA_I  in  TRB_WIDTH  memory read data, 1-cycle latency
FILL_O  out  PTR_W+1  unread words

Behaviour:
- Reset (RST_NI=0, async):
  - FSM goes to IDLE; owner register = T.
  - All outputs 0, FILL_O=0.
- FSM states: IDLE, WR_PH, RD_PH.
  - A slot is two cycles: WR_PH then RD_PH.
  - TURN_O of the owner is high in both cycles; the other side's TURN_O is low.
- Slot start (from IDLE or after RD_PH), evaluated only when ENABLE_I=1:
  - Preferred owner = side opposite the last owner (strict alternation).
  - If the preferred side has REQ=0 and the other has REQ=1, the other side gets the slot.
  - If neither requests, go to or stay in IDLE.
  - ENABLE_I=0 → IDLE after the current slot completes; the RD_PH return still delivers.
- WR_PH:
  - If owner WRITE=1 and owner WRITE_ALLOW_O=1: MEM_EN_O=1, MEM_WE_O=1, MEM_ADDR_O=owner WRITE_PTR, MEM_WDATA_O=owner DATA_I.
  - Otherwise no memory access.
- RD_PH:
  - If owner READ_ALLOW_O=1: MEM_EN_O=1, MEM_WE_O=0, MEM_ADDR_O=owner READ_PTR.
  - Next cycle: owner DATA_O <= MEM_RDATA_I and VALID_O pulses for 1 cycle.
  - Latency = 2 cycles from the RD_PH edge to VALID_O.
  - DATA_O holds its value until the next valid read.
- Allows (combinational from registered state, gated by ENABLE_I):
  - T_WRITE_ALLOW = FILL<TRB_DEPTH && !TRG_DELAYED_I
  - T_READ_ALLOW = 1
  - H_READ_ALLOW = FILL>0
  - H_WRITE_ALLOW = TRG_DELAYED_I (host may patch only a frozen buffer)
- Fill accounting:
  - +1 on a granted trace write.
  - −1 on a granted host read.
  - Host writes and trace reads leave FILL unchanged.
  - The two events never coincide (different phases).
  - FILL saturates at TRB_DEPTH and at 0 (guaranteed by the allows; the bench asserts it).
  - CLEAR_I sets FILL=0 next cycle and overrides any inc/dec in that cycle.
- Wrap-around: pointers are owned by the requesters. The arbiter passes addresses unmodified and does no modulo.
- MEM_* outputs are 0 in IDLE and whenever no access is granted.
- Reset mid-slot: the slot is aborted, the pending VALID is dropped, and FILL=0.

Test Plan:
1. Reset with both REQ=1 → all outputs 0; after release, T_TURN_O is high for 2 cycles, then H_TURN_O for 2 cycles, alternating.
2. T_REQ=1, H_REQ=0, T_WRITE=1, T_WRITE_PTR stepping 0..15 → 16 back-to-back T slots; FILL_O reaches 16, T_WRITE_ALLOW_O falls to 0, and the 17th write gives MEM_WE_O=0.
3. Fill to 3, then H_REQ=1, H_READ_PTR=1 with MEM_RDATA=0xDEADBEEF → H_VALID_O pulses 2 cycles after RD_PH, H_DATA_O=0xDEADBEEF, FILL_O=2.
4. FILL=0 with H slot → no MEM_EN in RD_PH and no H_VALID_O pulse; TRG_DELAYED_I=1 → T_WRITE_ALLOW_O=0, H_WRITE_ALLOW_O=1, and a host write reaches memory with FILL unchanged.
5. CLEAR_I asserted during a granted trace write at FILL=5 → FILL_O=0 next cycle.
6. RST_NI pulsed low during RD_PH → MEM_EN_O and TURN_O drop immediately, no VALID_O pulse, and the FSM restarts in IDLE.

Source files
------------

// File: rtl/trb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : trb_mem_arbiter
// Brief  : Slot arbiter for the single-port trace buffer (trace vs host side)
// Rev    : 1.0
// ============================================================================
module trb_mem_arbiter #(
  parameter int TRB_WIDTH = 32,
  parameter int TRB_DEPTH = 16,
  parameter int PTR_W     = $clog2(TRB_DEPTH)
) (
  input  logic                 CLK_I,
  input  logic                 RST_NI,
  input  logic                 ENABLE_I,
  input  logic                 CLEAR_I,
  input  logic                 TRG_DELAYED_I,
  input  logic                 T_REQ_I,
  input  logic                 H_REQ_I,
  input  logic                 T_WRITE_I,
  input  logic                 H_WRITE_I,
  input  logic [PTR_W-1:0]     T_WRITE_PTR_I,
  input  logic [PTR_W-1:0]     H_WRITE_PTR_I,
  input  logic [PTR_W-1:0]     T_READ_PTR_I,
  input  logic [PTR_W-1:0]     H_READ_PTR_I,
  input  logic [TRB_WIDTH-1:0] T_DATA_I,
  input  logic [TRB_WIDTH-1:0] H_DATA_I,
  output logic                 T_TURN_O,
  output logic                 H_TURN_O,
  output logic                 T_WRITE_ALLOW_O,
  output logic                 H_WRITE_ALLOW_O,
  output logic                 T_READ_ALLOW_O,
  output logic                 H_READ_ALLOW_O,
  output logic [TRB_WIDTH-1:0] T_DATA_O,
  output logic [TRB_WIDTH-1:0] H_DATA_O,
  output logic                 T_VALID_O,
  output logic                 H_VALID_O,
  output logic                 MEM_EN_O,
  output logic                 MEM_WE_O,
  output logic [PTR_W-1:0]     MEM_ADDR_O,
  output logic [TRB_WIDTH-1:0] MEM_WDATA_O,
  input  logic [TRB_WIDTH-1:0] MEM_RDATA_I,
  output logic [PTR_W:0]       FILL_O
);

  localparam logic [1:0]   c_st_idle = 2'd0;
  localparam logic [1:0]   c_st_wr   = 2'd1;
  localparam logic [1:0]   c_st_rd   = 2'd2;
  localparam logic         c_side_t  = 1'b0;
  localparam logic         c_side_h  = 1'b1;
  localparam logic [PTR_W:0] c_full  = (PTR_W+1)'(TRB_DEPTH);
  localparam logic [PTR_W:0] c_one   = (PTR_W+1)'(1);

  logic [1:0]           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 pref_q, pref_d;
  logic [PTR_W:0]       fill_q, fill_d;
  logic                 rd_pend_q;
  logic                 rd_side_q;
  logic                 t_valid_q, h_valid_q;
  logic [TRB_WIDTH-1:0] t_data_q, h_data_q;

  logic                 w_active;
  logic                 w_t_wr_allow, w_t_rd_allow, w_h_wr_allow, w_h_rd_allow;
  logic [1:0]           w_req;
  logic                 w_own_write, w_own_wr_allow, w_own_rd_allow;
  logic [PTR_W-1:0]     w_own_wptr, w_own_rptr;
  logic [TRB_WIDTH-1:0] w_own_wdata;
  logic                 w_wr_grant, w_rd_grant;
  logic                 w_mem_en, w_mem_we;
  logic [PTR_W-1:0]     w_mem_addr;
  logic [TRB_WIDTH-1:0] w_mem_wdata;
  logic                 w_t_turn, w_h_turn;

  // Allows are held low while reset is asserted so every output reads zero.
  assign w_active     = ENABLE_I & RST_NI;
  assign w_t_wr_allow = w_active & (fill_q < c_full) & ~TRG_DELAYED_I;
  assign w_t_rd_allow = w_active;
  assign w_h_rd_allow = w_active & (fill_q != '0);
  assign w_h_wr_allow = w_active & TRG_DELAYED_I;

  assign w_req          = {H_REQ_I, T_REQ_I};
  assign w_own_write    = (owner_q == c_side_h) ? H_WRITE_I     : T_WRITE_I;
  assign w_own_wr_allow = (owner_q == c_side_h) ? w_h_wr_allow  : w_t_wr_allow;
  assign w_own_rd_allow = (owner_q == c_side_h) ? w_h_rd_allow  : w_t_rd_allow;
  assign w_own_wptr     = (owner_q == c_side_h) ? H_WRITE_PTR_I : T_WRITE_PTR_I;
  assign w_own_rptr     = (owner_q == c_side_h) ? H_READ_PTR_I  : T_READ_PTR_I;
  assign w_own_wdata    = (owner_q == c_side_h) ? H_DATA_I      : T_DATA_I;

  assign w_wr_grant = (state_q == c_st_wr) & w_own_write & w_own_wr_allow;
  assign w_rd_grant = (state_q == c_st_rd) & w_own_rd_allow;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= c_st_idle;
      owner_q <= c_side_t;
      pref_q  <= c_side_t;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pref_q  <= pref_d;
    end
  end

  // A new slot is decided at IDLE or in the last cycle of the current slot.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    pref_d  = pref_q;
    case (state_q)
      c_st_wr: state_d = c_st_rd;
      default: begin
        state_d = c_st_idle;
        if (ENABLE_I) begin
          if (w_req[pref_q]) begin
            state_d = c_st_wr;
            owner_d = pref_q;
            pref_d  = ~pref_q;
          end else if (w_req[~pref_q]) begin
            state_d = c_st_wr;
            owner_d = ~pref_q;
            pref_d  = pref_q;
          end
        end
      end
    endcase
  end

  always_comb begin
    w_t_turn    = 1'b0;
    w_h_turn    = 1'b0;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (state_q != c_st_idle) begin
      w_t_turn = (owner_q == c_side_t);
      w_h_turn = (owner_q == c_side_h);
    end
    if (w_wr_grant) begin
      w_mem_en    = 1'b1;
      w_mem_we    = 1'b1;
      w_mem_addr  = w_own_wptr;
      w_mem_wdata = w_own_wdata;
    end else if (w_rd_grant) begin
      w_mem_en    = 1'b1;
      w_mem_addr  = w_own_rptr;
    end
  end

  always_comb begin
    fill_d = fill_q;
    if (CLEAR_I) begin
      fill_d = '0;
    end else if (w_wr_grant && (owner_q == c_side_t)) begin
      fill_d = fill_q + c_one;
    end else if (w_rd_grant && (owner_q == c_side_h)) begin
      fill_d = fill_q - c_one;
    end
  end

  // Memory returns data one cycle after the read; capture it the cycle after.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      fill_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_side_q <= c_side_t;
      t_valid_q <= 1'b0;
      h_valid_q <= 1'b0;
      t_data_q  <= '0;
      h_data_q  <= '0;
    end else begin
      fill_q    <= fill_d;
      rd_pend_q <= w_rd_grant;
      rd_side_q <= owner_q;
      t_valid_q <= rd_pend_q & (rd_side_q == c_side_t);
      h_valid_q <= rd_pend_q & (rd_side_q == c_side_h);
      if (rd_pend_q && (rd_side_q == c_side_t)) begin
        t_data_q <= MEM_RDATA_I;
      end
      if (rd_pend_q && (rd_side_q == c_side_h)) begin
        h_data_q <= MEM_RDATA_I;
      end
    end
  end

  assign T_TURN_O        = w_t_turn;
  assign H_TURN_O        = w_h_turn;
  assign T_WRITE_ALLOW_O = w_t_wr_allow;
  assign H_WRITE_ALLOW_O = w_h_wr_allow;
  assign T_READ_ALLOW_O  = w_t_rd_allow;
  assign H_READ_ALLOW_O  = w_h_rd_allow;
  assign T_DATA_O        = t_data_q;
  assign H_DATA_O        = h_data_q;
  assign T_VALID_O       = t_valid_q;
  assign H_VALID_O       = h_valid_q;
  assign MEM_EN_O        = w_mem_en;
  assign MEM_WE_O        = w_mem_we;
  assign MEM_ADDR_O      = w_mem_addr;
  assign MEM_WDATA_O     = w_mem_wdata;
  assign FILL_O          = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_trb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_trb_mem_arbiter
// Brief  : Directed plus randomized slot-level checks of trb_mem_arbiter
// Rev    : 1.0
// ============================================================================
module tb_trb_mem_arbiter;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int PW = 4;

  logic          CLK_I, RST_NI, ENABLE_I, CLEAR_I, TRG_DELAYED_I;
  logic          T_REQ_I, H_REQ_I, T_WRITE_I, H_WRITE_I;
  logic [PW-1:0] T_WRITE_PTR_I, H_WRITE_PTR_I, T_READ_PTR_I, H_READ_PTR_I;
  logic [W-1:0]  T_DATA_I, H_DATA_I;
  logic          T_TURN_O, H_TURN_O, T_WRITE_ALLOW_O, H_WRITE_ALLOW_O;
  logic          T_READ_ALLOW_O, H_READ_ALLOW_O, T_VALID_O, H_VALID_O;
  logic [W-1:0]  T_DATA_O, H_DATA_O, MEM_WDATA_O;
  logic          MEM_EN_O, MEM_WE_O;
  logic [PW-1:0] MEM_ADDR_O;
  logic [PW:0]   FILL_O;

  bit   [W-1:0]  ram [D];
  bit   [W-1:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  // slot-level reference model state
  bit [W-1:0] ref_mem [D];
  int         m_fill;
  bit         m_owner;      // 0 = trace, 1 = host
  bit         pend_v, pend_side;
  bit [W-1:0] pend_data, exp_t_data, exp_h_data;

  trb_mem_arbiter #(.TRB_WIDTH(W), .TRB_DEPTH(D), .PTR_W(PW)) dut (
    .CLK_I(CLK_I), .RST_NI(RST_NI), .ENABLE_I(ENABLE_I), .CLEAR_I(CLEAR_I),
    .TRG_DELAYED_I(TRG_DELAYED_I), .T_REQ_I(T_REQ_I), .H_REQ_I(H_REQ_I),
    .T_WRITE_I(T_WRITE_I), .H_WRITE_I(H_WRITE_I),
    .T_WRITE_PTR_I(T_WRITE_PTR_I), .H_WRITE_PTR_I(H_WRITE_PTR_I),
    .T_READ_PTR_I(T_READ_PTR_I), .H_READ_PTR_I(H_READ_PTR_I),
    .T_DATA_I(T_DATA_I), .H_DATA_I(H_DATA_I),
    .T_TURN_O(T_TURN_O), .H_TURN_O(H_TURN_O),
    .T_WRITE_ALLOW_O(T_WRITE_ALLOW_O), .H_WRITE_ALLOW_O(H_WRITE_ALLOW_O),
    .T_READ_ALLOW_O(T_READ_ALLOW_O), .H_READ_ALLOW_O(H_READ_ALLOW_O),
    .T_DATA_O(T_DATA_O), .H_DATA_O(H_DATA_O),
    .T_VALID_O(T_VALID_O), .H_VALID_O(H_VALID_O),
    .MEM_EN_O(MEM_EN_O), .MEM_WE_O(MEM_WE_O), .MEM_ADDR_O(MEM_ADDR_O),
    .MEM_WDATA_O(MEM_WDATA_O), .MEM_RDATA_I(mem_rdata), .FILL_O(FILL_O)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  // single-port synchronous RAM with one-cycle read latency
  always @(posedge CLK_I) begin
    if (MEM_EN_O) begin
      if (MEM_WE_O) ram[MEM_ADDR_O] <= MEM_WDATA_O;
      else          mem_rdata       <= ram[MEM_ADDR_O];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic do_reset();
    RST_NI = 1'b0;
    ENABLE_I = 0; CLEAR_I = 0; TRG_DELAYED_I = 0;
    T_REQ_I = 0; H_REQ_I = 0; T_WRITE_I = 0; H_WRITE_I = 0;
    T_WRITE_PTR_I = '0; H_WRITE_PTR_I = '0; T_READ_PTR_I = '0; H_READ_PTR_I = '0;
    T_DATA_I = '0; H_DATA_I = '0;
    @(negedge CLK_I);
    @(negedge CLK_I);
  endtask

  task automatic release_reset();
    #1 RST_NI = 1'b1;
  endtask

  // One complete slot; entered 1 time unit after the edge that starts WR_PH.
  // Requests drawn here decide the owner of the following slot.
  task automatic run_slot();
    logic tw, hw, trg, tq, hq, do_wr, do_rd, pref;
    logic [PW-1:0] wa, ra;
    logic [W-1:0] wd;
    int r;
    tw = ($urandom_range(0, 3) != 0);
    hw = ($urandom_range(0, 1) != 0);
    trg = ($urandom_range(0, 3) == 0);
    r = $urandom_range(1, 3);
    tq = r[0];
    hq = r[1];
    T_WRITE_I = tw; H_WRITE_I = hw; TRG_DELAYED_I = trg;
    T_REQ_I = tq; H_REQ_I = hq;
    T_WRITE_PTR_I = PW'($urandom); H_WRITE_PTR_I = PW'($urandom);
    T_READ_PTR_I  = PW'($urandom); H_READ_PTR_I  = PW'($urandom);
    T_DATA_I = $urandom; H_DATA_I = $urandom;
    if (!m_owner) begin
      do_wr = tw && (m_fill < D) && !trg;
      wa = T_WRITE_PTR_I; wd = T_DATA_I; ra = T_READ_PTR_I;
      do_rd = 1'b1;
    end else begin
      do_wr = hw && trg;
      wa = H_WRITE_PTR_I; wd = H_DATA_I; ra = H_READ_PTR_I;
      do_rd = (m_fill > 0);
    end
    @(negedge CLK_I);
    chk("wr_t_turn", T_TURN_O, !m_owner);
    chk("wr_h_turn", H_TURN_O, m_owner);
    chk("wr_mem_en", MEM_EN_O, do_wr);
    chk("wr_mem_we", MEM_WE_O, do_wr);
    chk("wr_addr", MEM_ADDR_O, do_wr ? wa : '0);
    chk("wr_wdata", MEM_WDATA_O, do_wr ? wd : '0);
    chk("wr_fill", FILL_O, m_fill);
    chk("wr_t_allow", T_WRITE_ALLOW_O, (m_fill < D) && !trg);
    chk("wr_valids", {T_VALID_O, H_VALID_O}, 2'b00);
    if (do_wr) begin
      ref_mem[wa] = wd;
      if (!m_owner) m_fill++;
    end
    tick();
    @(negedge CLK_I);
    chk("rd_t_turn", T_TURN_O, !m_owner);
    chk("rd_h_turn", H_TURN_O, m_owner);
    chk("rd_mem_en", MEM_EN_O, do_rd);
    chk("rd_mem_we", MEM_WE_O, 1'b0);
    chk("rd_addr", MEM_ADDR_O, do_rd ? ra : '0);
    chk("rd_wdata", MEM_WDATA_O, '0);
    chk("rd_fill", FILL_O, m_fill);
    chk("rd_fill_range", FILL_O <= D, 1'b1);
    chk("rd_h_allow", H_READ_ALLOW_O, m_fill > 0);
    if (pend_v) begin
      if (!pend_side) exp_t_data = pend_data;
      else            exp_h_data = pend_data;
    end
    chk("t_valid", T_VALID_O, pend_v && !pend_side);
    chk("h_valid", H_VALID_O, pend_v && pend_side);
    chk("t_data", T_DATA_O, exp_t_data);
    chk("h_data", H_DATA_O, exp_h_data);
    pend_v = do_rd;
    pend_side = m_owner;
    pend_data = ref_mem[ra];
    if (do_rd && m_owner) m_fill--;
    // strict alternation, falling back to whichever side is requesting
    pref = !m_owner;
    m_owner = (pref ? hq : tq) ? pref : !pref;
    tick();
  endtask

  initial begin
    int r;
    // ---- 1: reset with both requesting, then alternation
    do_reset();
    ENABLE_I = 1; T_REQ_I = 1; H_REQ_I = 1;
    #1;
    chk("rst_turns", {T_TURN_O, H_TURN_O}, 2'b00);
    chk("rst_allows", {T_WRITE_ALLOW_O, H_WRITE_ALLOW_O, T_READ_ALLOW_O, H_READ_ALLOW_O}, 4'b0);
    chk("rst_mem", {MEM_EN_O, MEM_WE_O}, 2'b00);
    chk("rst_addr", MEM_ADDR_O, '0);
    chk("rst_wdata", MEM_WDATA_O, '0);
    chk("rst_valid", {T_VALID_O, H_VALID_O}, 2'b00);
    chk("rst_data", {T_DATA_O, H_DATA_O}, '0);
    chk("rst_fill", FILL_O, '0);
    release_reset();
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge CLK_I);
      chk("alt_t_turn", T_TURN_O, ((k / 2) % 2) == 0);
      chk("alt_h_turn", H_TURN_O, ((k / 2) % 2) == 1);
    end

    // ---- randomized slots against the slot-level model
    do_reset();
    ENABLE_I = 1;
    r = $urandom_range(1, 3);
    T_REQ_I = r[0]; H_REQ_I = r[1];
    m_fill = 0; m_owner = !T_REQ_I;
    pend_v = 0; pend_side = 0; pend_data = '0;
    exp_t_data = '0; exp_h_data = '0;
    release_reset();
    tick();
    for (int s = 0; s < 200; s++) run_slot();

    // ---- 2: trace fills the buffer to full
    do_reset();
    ENABLE_I = 1; T_REQ_I = 1; T_WRITE_I = 1;
    release_reset();
    tick();
    for (int i = 0; i < 17; i++) begin
      T_WRITE_PTR_I = PW'(i);
      T_DATA_I = 32'h100 + i;
      @(negedge CLK_I);
      chk("full_we", MEM_WE_O, i < 16);
      chk("full_t_allow", T_WRITE_ALLOW_O, i < 16);
      tick();
      tick();
    end
    @(negedge CLK_I);
    chk("full_fill", FILL_O, 16);

    // ---- 3: host read after filling three words
    do_reset();
    ENABLE_I = 1; T_REQ_I = 1; T_WRITE_I = 1;
    release_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      T_WRITE_PTR_I = PW'(i);
      T_DATA_I = (i == 1) ? 32'hDEADBEEF : 32'h0 + i;
      tick();
      if (i == 2) begin
        T_REQ_I = 0; T_WRITE_I = 0; H_REQ_I = 1; H_READ_PTR_I = 4'd1;
      end
    end
    tick();
    H_REQ_I = 0;
    @(negedge CLK_I);
    chk("hrd_turn", H_TURN_O, 1'b1);
    chk("hrd_fill3", FILL_O, 3);
    tick();
    @(negedge CLK_I);
    chk("hrd_mem", {MEM_EN_O, MEM_WE_O}, 2'b10);
    chk("hrd_addr", MEM_ADDR_O, 1);
    tick();
    @(negedge CLK_I);
    chk("hrd_fill2", FILL_O, 2);
    chk("hrd_valid_early", H_VALID_O, 1'b0);
    tick();
    @(negedge CLK_I);
    chk("hrd_valid", H_VALID_O, 1'b1);
    chk("hrd_data", H_DATA_O, 32'hDEADBEEF);
    tick();
    @(negedge CLK_I);
    chk("hrd_valid_end", H_VALID_O, 1'b0);
    chk("hrd_data_hold", H_DATA_O, 32'hDEADBEEF);

    // ---- 4: empty host read, then frozen-buffer host write
    do_reset();
    ENABLE_I = 1; H_REQ_I = 1;
    release_reset();
    tick();
    H_REQ_I = 0;
    tick();
    @(negedge CLK_I);
    chk("empty_turn", H_TURN_O, 1'b1);
    chk("empty_mem_en", MEM_EN_O, 1'b0);
    chk("empty_h_allow", H_READ_ALLOW_O, 1'b0);
    tick();
    tick();
    @(negedge CLK_I);
    chk("empty_valid", H_VALID_O, 1'b0);
    TRG_DELAYED_I = 1;
    #1;
    chk("trg_t_wallow", T_WRITE_ALLOW_O, 1'b0);
    chk("trg_h_wallow", H_WRITE_ALLOW_O, 1'b1);
    H_REQ_I = 1; H_WRITE_I = 1; H_WRITE_PTR_I = 4'd5; H_DATA_I = 32'hA5A55A5A;
    tick();
    H_REQ_I = 0;
    @(negedge CLK_I);
    chk("hwr_we", {MEM_EN_O, MEM_WE_O}, 2'b11);
    chk("hwr_addr", MEM_ADDR_O, 5);
    chk("hwr_wdata", MEM_WDATA_O, 32'hA5A55A5A);
    tick();
    tick();
    @(negedge CLK_I);
    chk("hwr_fill", FILL_O, 0);
    TRG_DELAYED_I = 0; H_WRITE_I = 0;

    // ---- 5: clear during a granted trace write at fill 5
    do_reset();
    ENABLE_I = 1; T_REQ_I = 1; T_WRITE_I = 1;
    release_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      T_WRITE_PTR_I = PW'(i);
      tick();
      tick();
    end
    @(negedge CLK_I);
    chk("clr_fill5", FILL_O, 5);
    chk("clr_we", MEM_WE_O, 1'b1);
    CLEAR_I = 1;
    tick();
    CLEAR_I = 0;
    @(negedge CLK_I);
    chk("clr_fill0", FILL_O, 0);

    // ---- 6: reset pulse during RD_PH
    tick();
    tick();
    @(negedge CLK_I);
    chk("mid_fill1", FILL_O, 1);
    chk("mid_mem_en", MEM_EN_O, 1'b1);
    chk("mid_turn", T_TURN_O, 1'b1);
    T_REQ_I = 0; T_WRITE_I = 0;
    #1 RST_NI = 0;
    #1;
    chk("mid_rst_mem_en", MEM_EN_O, 1'b0);
    chk("mid_rst_turn", T_TURN_O, 1'b0);
    chk("mid_rst_fill", FILL_O, 0);
    #1 RST_NI = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge CLK_I);
      chk("mid_no_valid", T_VALID_O, 1'b0);
      chk("mid_idle_turn", T_TURN_O, 1'b0);
    end
    T_REQ_I = 1;
    tick();
    @(negedge CLK_I);
    chk("mid_restart_turn", T_TURN_O, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
